// File: rtl/text_tile_writer_pkg.sv
// Shared constants for the tile-BRAM text writer and the VGA renderer.
// Holds the default screen geometry, ASCII control codes, the printable
// range bounds and the writer FSM state encodings.
package text_tile_writer_pkg;

    localparam int DEFAULT_COLS = 80;   // 640 px / 8 px glyphs
    localparam int DEFAULT_ROWS = 30;   // 480 px / 16 px glyphs

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_FF       = 8'h0C;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    typedef logic [2:0] tt_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PUT     = 3'd1;
    localparam logic [2:0] ST_CLR_ALL = 3'd2;
    localparam logic [2:0] ST_SCRL_RD = 3'd3;
    localparam logic [2:0] ST_SCRL_WR = 3'd4;
    localparam logic [2:0] ST_CLR_ROW = 3'd5;

endpackage

// File: rtl/text_tile_writer.sv
// Scrolling text terminal front-end for the tile BRAM (port A).
// Consumes ASCII bytes over valid/ready and turns them into tile writes,
// with cursor tracking, LF/CR/BS/FF handling, full clear and one-line scroll.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   char_valid/ready  byte handshake, transfer on clk edge with both high
//   char_data         ASCII byte or control code
//   bram_we/addr      port A write enable and linear address (row*COLS+col)
//   bram_wdata        port A write data
//   bram_rdata        port A read data, one cycle after the address
//   cursor_col/row    current cursor position
//   busy              clear or scroll in progress
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | ready for a byte, no write
// PUT        | single write pulse of a glyph or BS blank
// CLR_ALL    | sweep 0x20 over the whole screen, one tile per cycle
// SCRL_RD    | present source address i+COLS (read)
// SCRL_WR    | write tile i with the data just read
// CLR_ROW    | blank the last row after a scroll
module text_tile_writer
    import text_tile_writer_pkg::*;
#(
    parameter int COLS       = DEFAULT_COLS,
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     char_valid,
    input  logic [DATA_WIDTH-1:0]    char_data,
    output logic                     char_ready,
    output logic                     bram_we,
    output logic [ADDR_WIDTH-1:0]    bram_addr,
    output logic [DATA_WIDTH-1:0]    bram_wdata,
    input  logic [DATA_WIDTH-1:0]    bram_rdata,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row,
    output logic                     busy
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [ADDR_WIDTH-1:0] A_ONE       = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_COLS      = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] A_LAST_TILE = ADDR_WIDTH'(ROWS * COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] A_SCRL_LAST = ADDR_WIDTH'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LAST_ROW  = ADDR_WIDTH'((ROWS - 1) * COLS);
    localparam logic [COL_W-1:0]      COL_ONE     = COL_W'(1);
    localparam logic [COL_W-1:0]      COL_MAX     = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]      ROW_ONE     = ROW_W'(1);
    localparam logic [ROW_W-1:0]      ROW_MAX     = ROW_W'(ROWS - 1);
    localparam logic [DATA_WIDTH-1:0] D_SPACE     = DATA_WIDTH'(ASCII_SPACE);

    tt_state_t               state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ADDR_WIDTH-1:0]   lin_q, lin_d;      // running row*COLS+col
    logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
    logic                    pend_q, pend_d;    // printable wrapped off the last row
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    accept;
    logic                    printable;

    assign accept    = char_valid & ready_q;
    assign printable = (char_data >= ASCII_PRINT_LO) && (char_data <= ASCII_PRINT_HI);

    // Outputs are set for the state being entered, so each sweep state shows
    // its own address on the port during its cycle. Clear sweeps lag by one
    // cycle so the reset image (we=0, addr=0) leads into write 0.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        col_d   = col_q;
        row_d   = row_q;
        lin_d   = lin_q;
        sweep_d = sweep_q;
        pend_d  = pend_q;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (accept) begin
                    ready_d = 1'b0;
                    if (printable) begin
                        we_d    = 1'b1;
                        addr_d  = lin_q;
                        wdata_d = char_data;
                        state_d = ST_PUT;
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            if (row_q == ROW_MAX) begin
                                lin_d  = A_LAST_ROW;
                                pend_d = 1'b1;
                            end else begin
                                row_d = row_q + ROW_ONE;
                                lin_d = lin_q + A_ONE;
                            end
                        end else begin
                            col_d = col_q + COL_ONE;
                            lin_d = lin_q + A_ONE;
                        end
                    end else if (char_data == ASCII_LF) begin
                        col_d = '0;
                        if (row_q == ROW_MAX) begin
                            lin_d   = A_LAST_ROW;
                            state_d = ST_SCRL_RD;
                            sweep_d = '0;
                            addr_d  = A_COLS;
                            busy_d  = 1'b1;
                        end else begin
                            row_d = row_q + ROW_ONE;
                            lin_d = lin_q - ADDR_WIDTH'(col_q) + A_COLS;
                        end
                    end else if (char_data == ASCII_CR) begin
                        col_d = '0;
                        lin_d = lin_q - ADDR_WIDTH'(col_q);
                    end else if (char_data == ASCII_BS) begin
                        if (col_q != '0) begin
                            col_d   = col_q - COL_ONE;
                            lin_d   = lin_q - A_ONE;
                            we_d    = 1'b1;
                            addr_d  = lin_q - A_ONE;
                            wdata_d = D_SPACE;
                            state_d = ST_PUT;
                        end
                    end else if (char_data == ASCII_FF) begin
                        state_d = ST_CLR_ALL;
                        sweep_d = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_PUT: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_SCRL_RD;
                    sweep_d = '0;
                    addr_d  = A_COLS;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_CLR_ALL: begin
                we_d    = 1'b1;
                addr_d  = sweep_q;
                wdata_d = D_SPACE;
                if (sweep_q == A_LAST_TILE) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                    col_d   = '0;
                    row_d   = '0;
                    lin_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    sweep_d = sweep_q + A_ONE;
                end
            end
            ST_SCRL_RD: begin
                we_d    = 1'b1;
                addr_d  = sweep_q;
                state_d = ST_SCRL_WR;
            end
            ST_SCRL_WR: begin
                if (sweep_q == A_SCRL_LAST) begin
                    we_d    = 1'b1;
                    addr_d  = A_LAST_ROW;
                    wdata_d = D_SPACE;
                    sweep_d = A_LAST_ROW;
                    state_d = ST_CLR_ROW;
                end else begin
                    addr_d  = sweep_q + A_ONE + A_COLS;
                    sweep_d = sweep_q + A_ONE;
                    state_d = ST_SCRL_RD;
                end
            end
            ST_CLR_ROW: begin
                if (sweep_q == A_LAST_TILE) begin
                    sweep_d = '0;
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = sweep_q + A_ONE;
                    wdata_d = D_SPACE;
                    sweep_d = sweep_q + A_ONE;
                end
            end
            default: begin
                state_d = ST_CLR_ALL;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLR_ALL;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= D_SPACE;
            col_q   <= '0;
            row_q   <= '0;
            lin_q   <= '0;
            sweep_q <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lin_q   <= lin_d;
            sweep_q <= sweep_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign char_ready = ready_q;
    assign busy       = busy_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    // During the copy the BRAM read register feeds the write port directly:
    // the tile read in SCRL_RD is on bram_rdata for the following SCRL_WR.
    assign bram_wdata = (state_q == ST_SCRL_WR) ? bram_rdata : wdata_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

endmodule

// File: tb/tb_text_tile_writer.sv
module tb_text_tile_writer;

    logic        clk;
    logic        rst_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        bram_we;
    logic [12:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic [7:0]  bram_rdata;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    logic [7:0]  mem [0:8191];
    logic [20:0] wq [$];
    int          nvec = 0;
    int          nerr = 0;

    text_tile_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port A of the tile BRAM: read-first, one cycle read latency.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bram_we === 1'b1) wq.push_back({bram_addr, bram_wdata});
    endtask

    task automatic hold(input logic [7:0] b, output int n);
        logic pre;
        pre = 1'b0;
        n = 0;
        char_valid = 1'b1;
        char_data  = b;
        while (!pre && n < 5000) begin
            pre = char_ready;
            tick();
            n++;
        end
        chk("accept", {31'd0, pre}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        hold(b, n);
        char_valid = 1'b0;
    endtask

    // Waits for the full-screen sweep to end and checks it wrote 0x20 to 0..2399.
    task automatic clear_check(input string tag);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (!char_ready && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_len"}, n, 2400);
        chk({tag, "_cnt"}, wq.size(), 2400);
        foreach (wq[i]) if (wq[i] !== {13'(i), 8'h20}) bad++;
        chk({tag, "_seq"}, bad, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_cur"}, {cursor_row, cursor_col}, 0);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int c;
        int bad;
        int i;
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;

        // 1: reset image, then the power-on clear sweep
        repeat (3) tick();
        chk("rst_we", {31'd0, bram_we}, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_wdata", bram_wdata, 8'h20);
        chk("rst_ready", {31'd0, char_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_cur", {cursor_row, cursor_col}, 0);
        wq.delete();
        rst_n = 1'b1;
        clear_check("clr0");

        // 2: single printable
        send(8'h41);
        chk("a_we", {31'd0, bram_we}, 1);
        chk("a_addr", bram_addr, 0);
        chk("a_wdata", bram_wdata, 8'h41);
        chk("a_cur", {cursor_row, cursor_col}, {5'd0, 7'd1});
        chk("a_ready0", {31'd0, char_ready}, 0);
        tick();
        chk("a_ready1", {31'd0, char_ready}, 1);
        chk("a_we_off", {31'd0, bram_we}, 0);

        // 3: line wrap, backspace, backspace at column 0
        send(8'h0D);
        chk("cr_cur", {cursor_row, cursor_col}, 0);
        chk("cr_we", {31'd0, bram_we}, 0);
        repeat (80) send(8'h42);
        send(8'h43);
        chk("wrap_addr", bram_addr, 80);
        chk("wrap_wdata", bram_wdata, 8'h43);
        chk("wrap_cur", {cursor_row, cursor_col}, {5'd1, 7'd1});
        send(8'h08);
        chk("bs_we", {31'd0, bram_we}, 1);
        chk("bs_addr", bram_addr, 80);
        chk("bs_wdata", bram_wdata, 8'h20);
        chk("bs_cur", {cursor_row, cursor_col}, {5'd1, 7'd0});
        send(8'h08);
        chk("bs0_we", {31'd0, bram_we}, 0);
        tick();
        chk("bs0_we2", {31'd0, bram_we}, 0);
        chk("bs0_cur", {cursor_row, cursor_col}, {5'd1, 7'd0});

        // 4: fill row 1 with 'X', walk to the last row, LF scrolls
        repeat (80) send(8'h58);
        chk("x_cur", {cursor_row, cursor_col}, {5'd2, 7'd0});
        repeat (27) send(8'h0A);
        chk("lf_cur", {cursor_row, cursor_col}, {5'd29, 7'd0});
        send(8'h0A);
        chk("scrl_addr0", bram_addr, 80);
        chk("scrl_we0", {31'd0, bram_we}, 0);
        bad = 0;
        c = 0;
        while (busy && c < 6000) begin
            if (c < 4640) begin
                if (c % 2 == 0) begin
                    if (bram_we !== 1'b0 || bram_addr !== 13'(c / 2 + 80)) bad++;
                end else begin
                    i = (c - 1) / 2;
                    if (bram_we !== 1'b1 || bram_addr !== 13'(i) ||
                        bram_wdata !== ((i < 80) ? 8'h58 : 8'h20)) bad++;
                end
            end else begin
                if (bram_we !== 1'b1 || bram_addr !== 13'(c - 4640 + 2320) ||
                    bram_wdata !== 8'h20) bad++;
            end
            c++;
            tick();
        end
        chk("scrl_seq", bad, 0);
        chk("scrl_busy", c, 4720);
        chk("scrl_cur", {cursor_row, cursor_col}, {5'd29, 7'd0});
        chk("scrl_ready", {31'd0, char_ready}, 1);
        chk("scrl_mem0", mem[0], 8'h58);
        chk("scrl_mem79", mem[79], 8'h58);
        chk("scrl_mem80", mem[80], 8'h20);

        // 5: FF from (17,5), then reset in the middle of a scroll
        send(8'h0C);
        wq.delete();
        clear_check("clrff0");
        repeat (5) send(8'h0A);
        send(8'h5A);
        chk("z_addr", bram_addr, 400);
        repeat (16) send(8'h5A);
        chk("z_cur", {cursor_row, cursor_col}, {5'd5, 7'd17});
        wq.delete();
        send(8'h0C);
        chk("ff_busy", {31'd0, busy}, 1);
        clear_check("clrff");
        repeat (30) send(8'h0A);
        repeat (100) tick();
        chk("mid_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_we", {31'd0, bram_we}, 0);
        chk("abort_addr", bram_addr, 0);
        wq.delete();
        clear_check("clrrst");

        // 6: bytes held during busy are not taken until IDLE
        send(8'h0C);
        wq.delete();
        hold(8'h01, n);
        char_valid = 1'b0;
        chk("hold_wait", n, 2401);
        chk("hold_wr", wq.size(), 2400);
        chk("hold_we", {31'd0, bram_we}, 0);
        send(8'h52);
        send(8'h52);
        chk("r_cur", {cursor_row, cursor_col}, {5'd0, 7'd2});
        wq.delete();
        hold(8'h0D, n);
        chk("cr_n", n, 2);
        chk("cr_col", {cursor_row, cursor_col}, 0);
        hold(8'h7F, n);
        chk("del_n", n, 2);
        char_valid = 1'b0;
        repeat (2) tick();
        chk("ctl_wr", wq.size(), 0);
        chk("ctl_cur", {cursor_row, cursor_col}, 0);
        chk("ctl_ready", {31'd0, char_ready}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
